// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the two writeback sources and the register-file write port.
// The sources use the master side; the arbiter uses the slave side.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                   src0_valid;
  logic                   src0_ready;
  logic [ADDR_W-1:0]      src0_rd;
  logic [DATA_W-1:0]      src0_data;
  logic                   src1_valid;
  logic                   src1_ready;
  logic [ADDR_W-1:0]      src1_rd;
  logic [DATA_W-1:0]      src1_data;
  logic                   wb_en;
  logic [ADDR_W-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic [(1<<ADDR_W)-1:0] pending;
  logic                   idle;

  modport master (
    output src0_valid, src0_rd, src0_data,
    output src1_valid, src1_rd, src1_data,
    input  src0_ready, src1_ready,
    input  wb_en, wb_addr, wb_data, pending, idle
  );

  modport slave (
    input  src0_valid, src0_rd, src0_data,
    input  src1_valid, src1_rd, src1_data,
    output src0_ready, src1_ready,
    output wb_en, wb_addr, wb_data, pending, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register file write port between two FIFO-buffered
// writeback sources, with a per-register "write outstanding" mask for hazard logic.
module regfile_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [1:0]             in_valid;
  logic [1:0]             ready_w;
  logic [1:0]             not_empty;
  logic [1:0]             push;
  logic [1:0]             grant_next;
  logic [1:0][ADDR_W-1:0] in_rd;
  logic [1:0][ADDR_W-1:0] head_addr;
  logic [1:0][DATA_W-1:0] in_data;
  logic [1:0][DATA_W-1:0] head_data;
  logic [1:0][NREG-1:0]   src_pending;
  logic [NREG-1:0]        pending_next;

  logic                   last_grant_reg;
  logic                   wb_en_reg;
  logic [ADDR_W-1:0]      wb_addr_reg;
  logic [DATA_W-1:0]      wb_data_reg;

  assign in_valid = {bus.src1_valid, bus.src0_valid};
  assign in_rd    = {bus.src1_rd, bus.src0_rd};
  assign in_data  = {bus.src1_data, bus.src0_data};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [ADDR_W-1:0] mem_addr [DEPTH];
      logic [DATA_W-1:0] mem_data [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic [NREG-1:0]   pend_next;

      // Ready looks only at the count, so a full FIFO refuses a push even while popping.
      assign ready_w[gi]   = count_reg < CNT_W'(DEPTH);
      assign not_empty[gi] = count_reg != '0;
      // Writes to r0 are accepted but dropped: they would be discarded by the regfile anyway.
      assign push[gi]      = in_valid[gi] & ready_w[gi] & (in_rd[gi] != '0);
      assign head_addr[gi] = mem_addr[rd_ptr_reg];
      assign head_data[gi] = mem_data[rd_ptr_reg];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (grant_next[gi]) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          if (push[gi] && !grant_next[gi]) count_reg <= count_reg + CNT_W'(1);
          else if (!push[gi] && grant_next[gi]) count_reg <= count_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem_addr[wr_ptr_reg] <= in_rd[gi];
          mem_data[wr_ptr_reg] <= in_data[gi];
        end
      end

      always_comb begin
        pend_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
          if (CNT_W'(k) < count_reg) pend_next[mem_addr[rd_ptr_reg + PTR_W'(k)]] = 1'b1;
        end
      end

      assign src_pending[gi] = pend_next;
    end
  endgenerate

  // On contention the source that did not win last time gets the port.
  always_comb begin
    grant_next = 2'b00;
    if (not_empty[0] && (!not_empty[1] || last_grant_reg)) grant_next = 2'b01;
    else if (not_empty[1]) grant_next = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
      wb_en_reg      <= 1'b0;
      wb_addr_reg    <= '0;
      wb_data_reg    <= '0;
    end else begin
      wb_en_reg <= |grant_next;
      if (grant_next[0]) begin
        last_grant_reg <= 1'b0;
        wb_addr_reg    <= head_addr[0];
        wb_data_reg    <= head_data[0];
      end else if (grant_next[1]) begin
        last_grant_reg <= 1'b1;
        wb_addr_reg    <= head_addr[1];
        wb_data_reg    <= head_data[1];
      end
    end
  end

  always_comb begin
    pending_next = src_pending[0] | src_pending[1];
    if (wb_en_reg) pending_next[wb_addr_reg] = 1'b1;
    pending_next[0] = 1'b0;
  end

  assign bus.src0_ready = ready_w[0];
  assign bus.src1_ready = ready_w[1];
  assign bus.wb_en      = wb_en_reg;
  assign bus.wb_addr    = wb_addr_reg;
  assign bus.wb_data    = wb_data_reg;
  assign bus.pending    = pending_next;
  assign bus.idle       = ~not_empty[0] & ~not_empty[1] & ~wb_en_reg;
endmodule
